lif_neuron_layer: RTL
=====================

LIF_NEURON_LAYER -- requirements
Module: lif_neuron_layer

Interface
REQ-001 SHALL have parameter M, default 8, number of input spike lines.
REQ-002 SHALL have parameter N, default 4, number of neurons in the layer.
REQ-003 SHALL have parameter W, default 8, width of each signed two's-complement weight.
REQ-004 SHALL have parameter V, default 8, width of each unsigned membrane potential.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  global advance; when low, all state is held.
REQ-008 SHALL have port input_spikes  input  M  presynaptic spikes, bit j = input j.
REQ-009 SHALL have port weights  input  N*M*W  weight for neuron n, input j at bits [(n*M+j)*W +: W].
REQ-010 SHALL have port threshold  input  V  firing threshold, shared by all neurons.
REQ-011 SHALL have port decay  input  V  leak subtracted per enabled update.
REQ-012 SHALL have port refractory_period  input  8  refractory length in enabled cycles.
REQ-013 SHALL have port reset_mode  input  1  0 = reset-to-zero, 1 = subtract-threshold.
REQ-014 SHALL have port spike_out  output  N  registered one-cycle spike pulse per neuron.
REQ-015 SHALL have port membrane  output  N*V  registered potential, neuron n at [n*V +: V].

Function
REQ-016 Stage 1, each enabled edge: current_n = signed sum of weights[n][j] over set input_spikes[j], computed at full precision, saturated to [-2^(V-1), 2^(V-1)-1], registered in cur_reg[n].
REQ-017 Stage 2, same enabled edge, per neuron using the previous cur_reg[n]: if ref_cnt[n] != 0 -> ref_cnt[n] decrements, membrane[n] held at 0, cur_reg input discarded, spike 0.
REQ-018 Otherwise, sum = membrane - min(membrane, decay) + cur_reg, computed signed at V+2 bits, clamped to [0, 2^V-1].
REQ-019 If sum >= threshold -> spike_out[n]=1, ref_cnt[n]=refractory_period, membrane = 0 (reset_mode=0) or sum - threshold (reset_mode=1); else spike_out[n]=0, membrane = sum.
REQ-020 Latency: spikes sampled at enabled edge k affect membrane and spike_out at enabled edge k+1.
REQ-021 spike_out SHALL be high for exactly one cycle per firing and SHALL be 0 on any edge where enable is low.
REQ-022 enable low: cur_reg, membrane, ref_cnt held unchanged; no decay, no decrement.
REQ-023 threshold=0 with ref_cnt=0: neuron fires every enabled update; refractory_period=0: neuron may fire on consecutive updates.
REQ-024 Neurons SHALL be fully independent; any subset may fire on the same edge.
REQ-025 threshold, decay, refractory_period, reset_mode SHALL be sampled on each enabled edge; a change takes effect on the next update.

Reset
REQ-026 reset high at an edge SHALL clear spike_out, membrane, cur_reg and all ref_cnt to 0, regardless of enable.
REQ-027 reset SHALL take priority over enable and over any in-progress refractory period or pending firing.
REQ-028 First enabled edge after reset integrates cur_reg=0 (membrane stays 0 for decay >= 0).

Verification (M=4, N=2, W=8, V=8)
REQ-029 Reset: assert reset 2 cycles with random inputs -> spike_out=0, membrane=0 on both neurons.
REQ-030 Integrate/fire: n0 weights all 10, spikes 4'b0011 every cycle, decay 0, threshold 50, refractory 0, mode 0 -> membrane 20, 40, then spike_out[0]=1 with membrane 0 on the third update; pattern repeats.
REQ-031 Subtract mode: same stimulus, reset_mode=1 -> at firing membrane=10; next updates 30, then fires at 50 -> 0.
REQ-032 Refractory: refractory_period=3 -> after a spike, 3 enabled updates with membrane 0, no spike, and input ignored; integration resumes on the 4th.
REQ-033 Saturation/leak: n1 weights all 127, spikes 4'b1111, threshold 255 -> current clamps to 127, membrane 127 then 254 then 255 -> spike; weights all -128 -> membrane floors at 0; decay 5 with no input -> membrane 40 steps 35, 30, ...
REQ-034 Enable/reset mid-run: drop enable for 5 cycles mid-integration -> membrane and ref_cnt frozen, spike_out 0; assert reset during refractory -> all state 0 and neuron can fire on the next qualifying update.

Source files
------------

// File: rtl/lif_neuron_layer.sv
// Layer of N leaky integrate-and-fire neurons fed by M shared presynaptic spike lines.
// Latency: input spikes are registered as a per-neuron current at enabled edge k and integrated at enabled edge k+1.
// Backpressure: none; enable low freezes all state and forces spike_out to 0.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   enable                global advance strobe; low holds every register
//   input_spikes [M]      presynaptic spikes, bit j = input j
//   weights [N*M*W]       signed weight of neuron n, input j at [(n*M+j)*W +: W]
//   threshold, decay [V]  shared firing threshold and per-update leak
//   refractory_period [8] updates a neuron stays silent after firing
//   reset_mode            0 = reset-to-zero, 1 = subtract-threshold after a spike
//   spike_out [N]         registered one-cycle spike pulse per neuron
//   membrane [N*V]        registered unsigned potential, neuron n at [n*V +: V]
module lif_neuron_layer #(
    parameter int M = 8,
    parameter int N = 4,
    parameter int W = 8,
    parameter int V = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [M-1:0]     input_spikes,
    input  logic [N*M*W-1:0] weights,
    input  logic [V-1:0]     threshold,
    input  logic [V-1:0]     decay,
    input  logic [7:0]       refractory_period,
    input  logic             reset_mode,
    output logic [N-1:0]     spike_out,
    output logic [N*V-1:0]   membrane
);

    // Accumulator wide enough for M full-scale weights and for the V-bit
    // saturation bounds, plus a guard bit so the signed compares never wrap.
    localparam int SW = W + $clog2(M) + 1;
    localparam int AW = ((SW > V) ? SW : V) + 1;
    localparam logic signed [AW-1:0] CUR_MAX = AW'((2 ** (V - 1)) - 1);
    localparam logic signed [AW-1:0] CUR_MIN = ~CUR_MAX;

    logic signed [AW-1:0] acc      [N];
    logic signed [V-1:0]  cur_next [N];
    logic signed [V-1:0]  cur_reg  [N];
    logic        [V-1:0]  mem      [N];
    logic        [7:0]    ref_cnt  [N];

    logic        [V-1:0]  leaked   [N];
    logic signed [V+1:0]  sum2     [N];
    logic        [V-1:0]  clamped  [N];
    logic        [V-1:0]  mem_fire [N];
    logic        [N-1:0]  fire;

    // Stage 1: synaptic current, saturated to the signed V-bit range.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            acc[n] = '0;
            for (int j = 0; j < M; j++) begin
                if (input_spikes[j]) begin
                    acc[n] = acc[n] + AW'($signed(weights[(n*M+j)*W +: W]));
                end
            end
            if (acc[n] > CUR_MAX) begin
                cur_next[n] = CUR_MAX[V-1:0];
            end else if (acc[n] < CUR_MIN) begin
                cur_next[n] = CUR_MIN[V-1:0];
            end else begin
                cur_next[n] = acc[n][V-1:0];
            end
        end
    end

    // Stage 2 datapath: leak (never below zero), add last cycle's current,
    // clamp to the unsigned V-bit range, then compare against threshold.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            leaked[n] = (mem[n] > decay) ? (mem[n] - decay) : '0;
            sum2[n]   = $signed({2'b00, leaked[n]})
                      + $signed({{2{cur_reg[n][V-1]}}, cur_reg[n]});
            // Bit V+1 is the sign; bit V set on a non-negative value means overflow.
            if (sum2[n][V+1]) begin
                clamped[n] = '0;
            end else if (sum2[n][V]) begin
                clamped[n] = '1;
            end else begin
                clamped[n] = sum2[n][V-1:0];
            end
            fire[n]     = (clamped[n] >= threshold);
            mem_fire[n] = reset_mode ? (clamped[n] - threshold) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_out <= '0;
            for (int n = 0; n < N; n++) begin
                cur_reg[n] <= '0;
                mem[n]     <= '0;
                ref_cnt[n] <= '0;
            end
        end else if (enable) begin
            for (int n = 0; n < N; n++) begin
                cur_reg[n] <= cur_next[n];
                if (ref_cnt[n] != 8'd0) begin
                    // Refractory: the pending current is dropped, not deferred.
                    ref_cnt[n]   <= ref_cnt[n] - 8'd1;
                    mem[n]       <= '0;
                    spike_out[n] <= 1'b0;
                end else if (fire[n]) begin
                    ref_cnt[n]   <= refractory_period;
                    mem[n]       <= mem_fire[n];
                    spike_out[n] <= 1'b1;
                end else begin
                    mem[n]       <= clamped[n];
                    spike_out[n] <= 1'b0;
                end
            end
        end else begin
            spike_out <= '0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_mem_out
        assign membrane[g*V +: V] = mem[g];
    end

endmodule
